mux_n_reg: RTL



---
 rtl/mux_n_reg_pkg.sv | 32 +++
 rtl/mux_n_reg_if.sv | 35 +++
 rtl/mux_n_comb.sv | 31 +++
 rtl/mux_n_reg.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mux_n_reg_pkg.sv
// ---------------------------------------------------------------------------
// mux_n_reg_pkg
//   Shared definitions for the N:1 select mux and its registered wrapper, also
//   used by the forwarding muxes:
//     sel_width()    : select width for an N-input mux (clog2, minimum 1)
//     DEF_VAL        : default word driven for an out-of-range select
//     MUX_N_OPERAND  : slice operand k out of a packed operand bus
//     occ_e          : occupancy of the registered output stage
// ---------------------------------------------------------------------------
`ifndef MUX_N_OPERAND
`define MUX_N_OPERAND(bus, k, w) bus[(k)*(w) +: (w)]
`endif

package mux_n_reg_pkg;

    localparam int DEF_NBITS = 32;
    localparam logic [DEF_NBITS-1:0] DEF_VAL = '0;

    // A 1-input or 2-input mux still needs a 1-bit select field.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Words held by the output stage: none, output register only,
    // output register plus skid register.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_OUT   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/mux_n_reg_if.sv
// ---------------------------------------------------------------------------
// mux_n_reg_if
//   Handshake bundle of mux_n_reg.
//     upstream   : i_valid, o_ready, i_sel, i_data (operand k at k*NBITS)
//     downstream : o_valid, i_ready, o_result, o_sel_err
//   slave  : the mux block side
//   master : the side that drives operands and consumes results
// ---------------------------------------------------------------------------
interface mux_n_reg_if
    import mux_n_reg_pkg::*;
#(
    parameter int NBITS   = 32,
    parameter int NINPUTS = 4
);
    localparam int SEL_W = sel_width(NINPUTS);

    logic                       i_valid;
    logic                       o_ready;
    logic [SEL_W-1:0]           i_sel;
    logic [NINPUTS*NBITS-1:0]   i_data;
    logic                       o_valid;
    logic                       i_ready;
    logic [NBITS-1:0]           o_result;
    logic                       o_sel_err;

    modport slave (
        input  i_valid, i_sel, i_data, i_ready,
        output o_ready, o_valid, o_result, o_sel_err
    );

    modport master (
        output i_valid, i_sel, i_data, i_ready,
        input  o_ready, o_valid, o_result, o_sel_err
    );
endinterface

// File: rtl/mux_n_comb.sv
// ---------------------------------------------------------------------------
// mux_n_comb
//   Purely combinational N:1 word select.
//     i_sel  : operand index
//     i_data : packed operands, operand k at [k*NBITS +: NBITS]
//     o_val  : selected operand, or DEFAULT_VAL when i_sel >= NINPUTS
//     o_err  : 1 when i_sel >= NINPUTS
// ---------------------------------------------------------------------------
module mux_n_comb #(
    parameter int               NBITS       = 32,
    parameter int               NINPUTS     = 4,
    parameter int               SEL_W       = 2,
    parameter logic [NBITS-1:0] DEFAULT_VAL = '0
) (
    input  logic [SEL_W-1:0]         i_sel,
    input  logic [NINPUTS*NBITS-1:0] i_data,
    output logic [NBITS-1:0]         o_val,
    output logic                     o_err
);
    // Out-of-range is the fall-through case; any matching index overrides it.
    always_comb begin
        o_val = DEFAULT_VAL;
        o_err = 1'b1;
        for (int k = 0; k < NINPUTS; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_val = `MUX_N_OPERAND(i_data, k, NBITS);
                o_err = 1'b0;
            end
        end
    end
endmodule

// File: rtl/mux_n_reg.sv
// ---------------------------------------------------------------------------
// mux_n_reg
//   Registered N:1 select with a valid/ready handshake and a one-entry skid
//   buffer. o_ready is a flop (never a function of i_ready), so this stage can
//   be dropped into a pipeline without lengthening the ready path.
//     i_clk   : clock, rising edge
//     i_rst_n : synchronous active-low reset
//     bus     : mux_n_reg_if.slave (upstream operands/select, downstream result)
//   Out-of-range selects yield DEFAULT_VAL with o_sel_err=1.
// ---------------------------------------------------------------------------
module mux_n_reg
    import mux_n_reg_pkg::*;
#(
    parameter int               NBITS       = 32,
    parameter int               NINPUTS     = 4,
    parameter logic [NBITS-1:0] DEFAULT_VAL = NBITS'(DEF_VAL)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    mux_n_reg_if.slave  bus
);
    localparam int SEL_W = sel_width(NINPUTS);

    if (NINPUTS < 2 || NINPUTS > 16) begin : g_bad_ninputs
        $error("mux_n_reg: NINPUTS must be within 2..16");
    end

    // Selected word, evaluated only at accept edges.
    logic [NBITS-1:0] mux_val;
    logic             mux_err;

    mux_n_comb #(
        .NBITS       (NBITS),
        .NINPUTS     (NINPUTS),
        .SEL_W       (SEL_W),
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_mux (
        .i_sel  (bus.i_sel),
        .i_data (bus.i_data),
        .o_val  (mux_val),
        .o_err  (mux_err)
    );

    occ_e             occ_q, occ_nx;
    logic             valid_q, ready_q;
    logic [NBITS-1:0] res_q, skid_res_q;
    logic             err_q, skid_err_q;

    logic accept, drain;
    logic load_out, load_from_skid, load_skid;

    assign accept = bus.i_valid && ready_q;
    assign drain  = valid_q && bus.i_ready;

    always_comb begin
        occ_nx         = occ_q;
        load_out       = 1'b0;
        load_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (accept) begin
                    load_out = 1'b1;
                    occ_nx   = OCC_OUT;
                end
            end
            OCC_OUT: begin
                if (accept && drain) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    occ_nx    = OCC_FULL;
                end else if (drain) begin
                    occ_nx = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                // ready_q is low here, so no accept can coincide.
                if (drain) begin
                    load_from_skid = 1'b1;
                    occ_nx         = OCC_OUT;
                end
            end
            default: occ_nx = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            occ_q      <= OCC_EMPTY;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            res_q      <= '0;
            err_q      <= 1'b0;
            skid_res_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            occ_q   <= occ_nx;
            // Handshake flags are registered copies of the next occupancy.
            valid_q <= (occ_nx != OCC_EMPTY);
            ready_q <= (occ_nx != OCC_FULL);
            if (load_out) begin
                res_q <= mux_val;
                err_q <= mux_err;
            end else if (load_from_skid) begin
                res_q <= skid_res_q;
                err_q <= skid_err_q;
            end
            if (load_skid) begin
                skid_res_q <= mux_val;
                skid_err_q <= mux_err;
            end
        end
    end

    assign bus.o_valid   = valid_q;
    assign bus.o_ready   = ready_q;
    assign bus.o_result  = res_q;
    assign bus.o_sel_err = err_q;

endmodule
